// File: rtl/ram_access_unit.sv
// ram_access_unit: fixed-latency single-port RAM front end; a request must be held until its ACCESS cycle
module ram_access_unit #(
  parameter int LAT   = 2,
  parameter int DEPTH = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ramREN,
  input  logic        ramWEN,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output logic [1:0]  ramstate
);
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [29:0] cap_addr, cap_addr_n;
  logic        cap_op, cap_op_n;
  logic [31:0] cap_data, cap_data_n;
  logic [31:0] mem [DEPTH];
  logic [29:0] widx;
  logic        one, valid, invalid, match, access, unused_ok;
  assign widx      = ramaddr[31:2];
  assign unused_ok = ^ramaddr[1:0];
  assign one       = ramREN ^ ramWEN;
  assign valid     = one && ({2'b0, widx} < 32'(DEPTH));
  assign invalid   = (ramREN & ramWEN) | (one & !valid);
  // a captured access survives only while the identical request is held
  assign match     = state != IDLE && one && widx == cap_addr && ramWEN == cap_op;
  assign access    = !RST && state == DONE && match;
  assign ramstate  = RST ? FREE : invalid ? ERROR : access ? ACCESS : (match || valid) ? BUSY : FREE;
  assign ramload   = (access && !cap_op) ? mem[cap_addr[AW-1:0]] : 32'h0;
  always_comb begin
    state_n    = IDLE;
    cnt_n      = cnt;
    cap_addr_n = cap_addr;
    cap_op_n   = cap_op;
    cap_data_n = cap_data;
    if (invalid) state_n = IDLE;
    else if (match && state == WAIT) begin
      state_n = cnt == 4'd1 ? DONE : WAIT;
      cnt_n   = cnt - 4'd1;
    end else if (match) state_n = IDLE;
    else if (valid) begin
      cap_addr_n = widx;
      cap_op_n   = ramWEN;
      cap_data_n = ramstore;
      state_n    = LAT == 1 ? DONE : WAIT;
      cnt_n      = 4'(LAT - 1);
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      cap_addr <= 30'd0;
      cap_op   <= 1'b0;
      cap_data <= 32'h0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      cap_addr <= cap_addr_n;
      cap_op   <= cap_op_n;
      cap_data <= cap_data_n;
    end
  end
  always_ff @(posedge CLK) begin
    if (access && cap_op) mem[cap_addr[AW-1:0]] <= cap_data;
  end
endmodule

// File: tb/tb_ram_access_unit.sv
// tb_ram_access_unit: directed vectors on a LAT=2 and a LAT=3 instance, checked by a per-cycle scoreboard
module tb_ram_access_unit;
  localparam logic [1:0] F = 2'd0, B = 2'd1, A = 2'd2, E = 2'd3;
  logic        CLK = 0, RST = 1;
  logic        ren2 = 0, wen2 = 0, ren3 = 0, wen3 = 0;
  logic [31:0] addr2 = 0, store2 = 0, addr3 = 0, store3 = 0;
  logic [31:0] ld2, ld3;
  logic [1:0]  st2, st3;
  int          errors = 0, checks = 0;
  typedef struct {
    int          d;
    bit          chk;
    logic [1:0]  st;
    logic [31:0] ld;
    string       nm;
  } exp_t;
  exp_t q[$];

  ram_access_unit #(.LAT(2), .DEPTH(1024)) u2 (.CLK(CLK), .RST(RST), .ramREN(ren2), .ramWEN(wen2),
    .ramaddr(addr2), .ramstore(store2), .ramload(ld2), .ramstate(st2));
  ram_access_unit #(.LAT(3), .DEPTH(1024)) u3 (.CLK(CLK), .RST(RST), .ramREN(ren3), .ramWEN(wen3),
    .ramaddr(addr3), .ramstore(store3), .ramload(ld3), .ramstate(st3));

  always #5 CLK = ~CLK;

  task automatic step(input int d, input logic rst, r, w, input logic [31:0] a, s,
                      input bit chk, input logic [1:0] es, input logic [31:0] el, input string nm);
    exp_t e;
    @(posedge CLK);
    #1;
    RST = rst;
    ren2 = d == 2 && r; wen2 = d == 2 && w; addr2 = d == 2 ? a : 0; store2 = d == 2 ? s : 0;
    ren3 = d == 3 && r; wen3 = d == 3 && w; addr3 = d == 3 ? a : 0; store3 = d == 3 ? s : 0;
    e.d = d; e.chk = chk; e.st = es; e.ld = el; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic idle(input int d, input int n, input string nm);
    for (int i = 0; i < n; i++) step(d, 0, 0, 0, 0, 0, 1, F, 0, nm);
  endtask

  always @(negedge CLK) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [1:0]  st;
      logic [31:0] ld;
      e  = q.pop_front();
      st = e.d == 2 ? st2 : st3;
      ld = e.d == 2 ? ld2 : ld3;
      if (e.chk) begin
        checks += 2;
        if (st !== e.st) begin
          errors++;
          $display("FAIL %s lat%0d ramstate got %0d want %0d", e.nm, e.d, st, e.st);
        end
        if (ld !== e.ld) begin
          errors++;
          $display("FAIL %s lat%0d ramload got %h want %h", e.nm, e.d, ld, e.ld);
        end
      end
    end
  end

  initial begin
    step(2, 1, 0, 0, 0, 0, 1, F, 0, "reset");
    step(2, 1, 1, 0, 32'h40, 0, 1, F, 0, "reset_req");
    idle(2, 3, "idle");
    // LAT=2 write then read back
    step(2, 0, 0, 1, 32'h40, 32'hDEADBEEF, 1, B, 0, "wr40_t0");
    step(2, 0, 0, 1, 32'h40, 32'hDEADBEEF, 1, B, 0, "wr40_t1");
    step(2, 0, 0, 1, 32'h40, 32'hDEADBEEF, 1, A, 0, "wr40_t2");
    idle(2, 1, "idle");
    step(2, 0, 1, 0, 32'h40, 0, 1, B, 0, "rd40_t0");
    step(2, 0, 1, 0, 32'h40, 0, 1, B, 0, "rd40_t1");
    step(2, 0, 1, 0, 32'h40, 0, 1, A, 32'hDEADBEEF, "rd40_t2");
    idle(2, 1, "idle");
    // invalid requests
    step(2, 0, 1, 1, 32'h40, 32'h1, 1, E, 0, "both");
    idle(2, 1, "idle");
    step(2, 0, 1, 0, 32'h43, 0, 1, B, 0, "rd40b_t0");
    step(2, 0, 1, 0, 32'h40, 0, 1, B, 0, "rd40b_t1");
    step(2, 0, 1, 0, 32'h41, 0, 1, A, 32'hDEADBEEF, "rd40b_t2");
    step(2, 0, 1, 0, 32'h1000, 0, 1, E, 0, "oob");
    step(2, 0, 0, 1, 32'h0FFC, 32'h5, 1, B, 0, "top_ok");
    step(2, 0, 1, 1, 32'h0FFC, 32'h5, 1, E, 0, "err_mid");
    idle(2, 1, "idle");
    // held read: one ACCESS every LAT+1 cycles
    step(2, 0, 1, 0, 32'h40, 0, 1, B, 0, "hold_t0");
    step(2, 0, 1, 0, 32'h40, 0, 1, B, 0, "hold_t1");
    step(2, 0, 1, 0, 32'h40, 0, 1, A, 32'hDEADBEEF, "hold_t2");
    step(2, 0, 1, 0, 32'h40, 0, 1, B, 0, "hold_t3");
    step(2, 0, 1, 0, 32'h40, 0, 1, B, 0, "hold_t4");
    step(2, 0, 1, 0, 32'h40, 0, 1, A, 32'hDEADBEEF, "hold_t5");
    step(2, 0, 1, 0, 32'h40, 0, 1, B, 0, "hold_t6");
    step(2, 0, 0, 0, 0, 0, 0, F, 0, "hold_rel");
    idle(2, 1, "idle");
    // reset in the middle of writes
    step(2, 0, 0, 1, 32'h20, 32'hAAAA5555, 1, B, 0, "wr20_t0");
    step(2, 0, 0, 1, 32'h20, 32'hAAAA5555, 1, B, 0, "wr20_t1");
    step(2, 0, 0, 1, 32'h20, 32'hAAAA5555, 1, A, 0, "wr20_t2");
    idle(2, 1, "idle");
    step(2, 0, 0, 1, 32'h20, 32'h12345678, 1, B, 0, "rstw_t0");
    step(2, 1, 0, 1, 32'h20, 32'h12345678, 1, F, 0, "rstw_t1");
    step(2, 0, 0, 0, 0, 0, 1, F, 0, "rstw_t2");
    step(2, 0, 0, 1, 32'h20, 32'h12345678, 1, B, 0, "rstd_t0");
    step(2, 0, 0, 1, 32'h20, 32'h12345678, 1, B, 0, "rstd_t1");
    step(2, 1, 0, 1, 32'h20, 32'h12345678, 1, F, 0, "rstd_t2");
    step(2, 0, 0, 0, 0, 0, 1, F, 0, "rstd_t3");
    step(2, 0, 1, 0, 32'h20, 0, 1, B, 0, "rd20_t0");
    step(2, 0, 1, 0, 32'h20, 0, 1, B, 0, "rd20_t1");
    step(2, 0, 1, 0, 32'h20, 0, 1, A, 32'hAAAA5555, "rd20_t2");
    idle(3, 1, "idle");
    // LAT=3 preload
    for (int i = 0; i < 3; i++) step(3, 0, 0, 1, 32'h84, 32'hCAFEF00D, 1, B, 0, "wr84");
    step(3, 0, 0, 1, 32'h84, 32'hCAFEF00D, 1, A, 0, "wr84_t3");
    idle(3, 1, "idle");
    for (int i = 0; i < 3; i++) step(3, 0, 0, 1, 32'h10, 32'h11111111, 1, B, 0, "wr10");
    step(3, 0, 0, 1, 32'h10, 32'h11111111, 1, A, 0, "wr10_t3");
    idle(3, 1, "idle");
    // address switch restarts the access
    step(3, 0, 1, 0, 32'h80, 0, 1, B, 0, "sw_t0");
    step(3, 0, 1, 0, 32'h84, 0, 1, B, 0, "sw_t1");
    step(3, 0, 1, 0, 32'h84, 0, 1, B, 0, "sw_t2");
    step(3, 0, 1, 0, 32'h84, 0, 1, B, 0, "sw_t3");
    step(3, 0, 1, 0, 32'h84, 0, 1, A, 32'hCAFEF00D, "sw_t4");
    idle(3, 1, "idle");
    // op switch drops a write
    step(3, 0, 0, 1, 32'h10, 32'h22222222, 1, B, 0, "op_t0");
    step(3, 0, 1, 0, 32'h10, 0, 1, B, 0, "op_t1");
    step(3, 0, 1, 0, 32'h10, 0, 1, B, 0, "op_t2");
    step(3, 0, 1, 0, 32'h10, 0, 1, B, 0, "op_t3");
    step(3, 0, 1, 0, 32'h10, 0, 1, A, 32'h11111111, "op_t4");
    idle(3, 1, "idle");
    // deassert drops a write; data changed during WAIT is ignored
    step(3, 0, 0, 1, 32'h10, 32'h33333333, 1, B, 0, "drop_t0");
    step(3, 0, 0, 0, 0, 0, 0, F, 0, "drop_t1");
    idle(3, 1, "idle");
    step(3, 0, 0, 1, 32'h84, 32'h0BADF00D, 1, B, 0, "cap_t0");
    step(3, 0, 0, 1, 32'h84, 32'h99999999, 1, B, 0, "cap_t1");
    step(3, 0, 0, 1, 32'h84, 32'h77777777, 1, B, 0, "cap_t2");
    step(3, 0, 0, 1, 32'h84, 32'h66666666, 1, A, 0, "cap_t3");
    idle(3, 1, "idle");
    for (int i = 0; i < 3; i++) step(3, 0, 1, 0, 32'h10, 0, 1, B, 0, "rd10");
    step(3, 0, 1, 0, 32'h10, 0, 1, A, 32'h11111111, "rd10_t3");
    for (int i = 0; i < 3; i++) step(3, 0, 1, 0, 32'h84, 0, 1, B, 0, "rd84");
    step(3, 0, 1, 0, 32'h84, 0, 1, A, 32'h0BADF00D, "rd84_t3");
    idle(3, 2, "idle");
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge CLK);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain scoreboard left %0d want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
